// File: rtl/ls_mem_responder.sv
// Load/store memory responder: one outstanding request, programmable access delay,
// big-endian byte lanes over an internal word array, sign/zero-extended load data.
module ls_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [0:1]  req_size,
   input  logic        req_signed,
   input  logic [0:31] req_addr,
   input  logic [0:31] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [0:31] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   state_t         state;
   logic [CW-1:0]  wait_cnt;
   logic           l_write;
   logic           l_signed;
   logic [0:1]     l_size;
   logic [0:31]    l_addr;
   logic [0:31]    l_wdata;
   logic [0:31]    mem [DEPTH_WORDS];
   logic [0:31]    rd_word;
   logic           acc_err;
   logic           err_c;
   logic [AW-1:0]  idx;
   logic [0:31]    merged;
   logic [0:31]    fmt;
   logic [0:7]     sel_b;
   logic [0:15]    sel_h;

   assign idx = l_addr[30-AW:29];

   always_comb begin
      err_c = (l_size == 2'b11)
           || ((l_size == 2'b01) && l_addr[31])
           || ((l_size == 2'b10) && (l_addr[30:31] != 2'b00))
           || ({2'b00, l_addr[0:29]} >= 32'(DEPTH_WORDS));
   end

   // Byte lane 0 is bits [0:7] (big-endian), so the lane offset indexes upward from the MSB.
   always_comb begin
      merged = mem[idx];
      case (l_size)
         2'b00:   merged[{l_addr[30:31], 3'b000} +: 8]  = l_wdata[24:31];
         2'b01:   merged[{l_addr[30], 4'b0000} +: 16]   = l_wdata[16:31];
         default: merged = l_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == ACCESS && l_write && !err_c)
         mem[idx] <= merged;
   end

   always_comb begin
      sel_b = rd_word[{l_addr[30:31], 3'b000} +: 8];
      sel_h = rd_word[{l_addr[30], 4'b0000} +: 16];
      fmt   = '0;
      if (!acc_err && !l_write) begin
         case (l_size)
            2'b00:   fmt = {{24{l_signed & sel_b[0]}}, sel_b};
            2'b01:   fmt = {{16{l_signed & sel_h[0]}}, sel_h};
            default: fmt = rd_word;
         endcase
      end
   end

   // The array word is captured in ACCESS; extension is registered on the first RESP cycle,
   // which gives resp_valid its WAIT_CYCLES+2 latency from acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         wait_cnt   <= '0;
         l_write    <= 1'b0;
         l_signed   <= 1'b0;
         l_size     <= '0;
         l_addr     <= '0;
         l_wdata    <= '0;
         rd_word    <= '0;
         acc_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  l_write   <= req_write;
                  l_size    <= req_size;
                  l_signed  <= req_signed;
                  l_addr    <= req_addr;
                  l_wdata   <= req_wdata;
                  req_ready <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
               end
            end
            WAIT: begin
               if (wait_cnt == CW'(WAIT_CYCLES - 1)) begin
                  wait_cnt <= '0;
                  state    <= ACCESS;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ACCESS: begin
               rd_word <= mem[idx];
               acc_err <= err_c;
               state   <= RESP;
            end
            RESP: begin
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= fmt;
                  resp_err   <= acc_err;
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ls_mem_responder.sv
// Scoreboard bench for ls_mem_responder: a WAIT_CYCLES=2 instance for the main traffic
// and a WAIT_CYCLES=0 instance sharing the request bus for the zero-wait latency.
module tb_ls_mem_responder;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_valid0 = 1'b0;
   logic        req_ready, req_ready0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid, resp_valid0;
   logic        resp_ready = 1'b0, resp_ready0 = 1'b0;
   logic [31:0] resp_rdata, resp_rdata0;
   logic        resp_err, resp_err0;

   int unsigned checks = 0;
   int unsigned failures = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned lat;
   } exp_t;
   exp_t sb_q[$];

   logic [31:0] mdl [0:63];

   always #5 clk = ~clk;

   ls_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   ls_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_rdata(resp_rdata0), .resp_err(resp_err0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent little-endian-numbered reference for big-endian lane selection.
   function automatic logic [31:0] mdl_load(input logic [31:0] wd, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(wd >> (8 * (3 - int'(a[1:0]))));
      h = 16'(wd >> (16 * (1 - int'(a[1]))));
      case (sz)
         2'd0:    return sg ? {{24{b[7]}}, b} : {24'h0, b};
         2'd1:    return sg ? {{16{h[15]}}, h} : {16'h0, h};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] mdl_store(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [31:0] a, input logic [31:0] wd);
      int unsigned sh;
      case (sz)
         2'd0: begin
            sh = 8 * (3 - int'(a[1:0]));
            return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
         end
         2'd1: begin
            sh = 16 * (1 - int'(a[1]));
            return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
         end
         default: return wd;
      endcase
   endfunction

   task automatic xact(input bit sel, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int unsigned hold);
      exp_t e;
      int unsigned lat;
      @(negedge clk);
      chk("req_ready_idle", sel ? req_ready0 : req_ready, 1);
      req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
      e.rdata = er; e.err = ee; e.lat = sel ? 2 : W + 2;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_valid0 = 1'b0;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_size = 2'b11;
      lat = 0;
      while ((sel ? resp_valid0 : resp_valid) == 1'b0 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb_q.pop_front();
      chk("latency", lat, e.lat);
      chk("rdata", sel ? resp_rdata0 : resp_rdata, e.rdata);
      chk("err", sel ? resp_err0 : resp_err, e.err);
      for (int unsigned i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", sel ? resp_valid0 : resp_valid, 1);
         chk("hold_rdata", sel ? resp_rdata0 : resp_rdata, e.rdata);
         chk("hold_req_ready", sel ? req_ready0 : req_ready, 0);
      end
      @(negedge clk);
      if (sel) resp_ready0 = 1'b1; else resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0; resp_ready0 = 1'b0;
      chk("valid_drop", sel ? resp_valid0 : resp_valid, 0);
      chk("req_ready_back", sel ? req_ready0 : req_ready, 1);
   endtask

   initial begin
      logic [31:0] a, wd, er;
      logic [1:0]  sz;
      logic        sg, w;

      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_err", resp_err, 0);
      reset = 1'b0;

      // Directed traffic.
      xact(0, 1, 2'd2, 0, 32'h10, 32'h1234_5678, 32'h0, 0, 0);
      xact(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_5678, 0, 0);
      xact(0, 0, 2'd0, 1, 32'h10, 32'h0, 32'h0000_0012, 0, 0);
      xact(0, 0, 2'd1, 0, 32'h12, 32'h0, 32'h0000_5678, 0, 0);
      xact(0, 1, 2'd0, 0, 32'h13, 32'h0000_00F0, 32'h0, 0, 0);
      xact(0, 0, 2'd0, 1, 32'h13, 32'h0, 32'hFFFF_FFF0, 0, 0);
      xact(0, 0, 2'd0, 0, 32'h13, 32'h0, 32'h0000_00F0, 0, 0);
      xact(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_56F0, 0, 0);
      xact(0, 1, 2'd1, 0, 32'h11, 32'h0000_BBBB, 32'h0, 1, 0);
      xact(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_56F0, 0, 0);
      xact(0, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 1, 0);
      xact(0, 0, 2'd2, 0, 32'h100, 32'h0, 32'h0, 1, 0);
      xact(0, 0, 2'd0, 0, 32'h104, 32'h0, 32'h0, 1, 0);
      xact(0, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 0);
      xact(0, 0, 2'd1, 1, 32'h10, 32'h0, 32'h0000_1234, 0, 5);

      // Reset while a store sits in WAIT: the store must be dropped.
      xact(0, 1, 2'd2, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 0);
      xact(0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0);
      @(negedge clk);
      req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_resp_valid", resp_valid, 0);
      chk("mid_rst_rdata", resp_rdata, 0);
      chk("mid_rst_err", resp_err, 0);
      @(negedge clk);
      reset = 1'b0;
      xact(0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0);

      // Zero-wait instance.
      xact(1, 1, 2'd2, 0, 32'h40, 32'hA5A5_5A5A, 32'h0, 0, 0);
      xact(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'hA5A5_5A5A, 0, 0);
      xact(1, 0, 2'd1, 1, 32'h40, 32'h0, 32'hFFFF_A5A5, 0, 0);
      xact(1, 0, 2'd0, 0, 32'h43, 32'h0, 32'h0000_005A, 0, 0);

      // Random traffic against a reference model on words 40..47.
      for (int i = 40; i < 48; i++) begin
         wd = $urandom;
         mdl[i] = wd;
         xact(0, 1, 2'd2, 0, 32'(i * 4), wd, 32'h0, 0, 0);
      end
      for (int i = 0; i < 24; i++) begin
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 2));
         sg = 1'($urandom_range(0, 1));
         a  = 32'(160 + $urandom_range(0, 31));
         if (sz == 2'd1) a[0] = 1'b0;
         if (sz == 2'd2) a[1:0] = 2'b00;
         wd = $urandom;
         if (w) begin
            mdl[a[7:2]] = mdl_store(mdl[a[7:2]], sz, a, wd);
            er = 32'h0;
         end else begin
            er = mdl_load(mdl[a[7:2]], sz, sg, a);
         end
         xact(0, w, sz, sg, a, wd, er, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
